fc_in_loader: RTL and testbench

- Serial-to-parallel activation loader placed directly upstream of the fully-connected neuron layer.
- Accepts one WIDTH-bit activation per cycle over a valid/ready stream and assembles IN-entry frames.
- Presents each complete frame as the layer's parallel input array `x[0:IN-1]`, held stable until the consumer acknowledges it.
- Double buffered: frame n+1 is filled while frame n is held at the output.

---
 rtl/fc_in_loader.sv | 92 +++++++++
 tb/tb_fc_in_loader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_in_loader.sv
// Serial-to-parallel activation loader feeding the fully-connected layer.
// Double buffered: one frame fills while the previous one is held on x.
module fc_in_loader #(
  parameter int WIDTH = 8,
  parameter int IN    = 400
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [WIDTH-1:0] x [0:IN-1],
  output logic             x_valid,
  input  logic             x_ack,
  output logic             err
);

  localparam int               IDX_W    = (IN > 1) ? $clog2(IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN - 1);

  logic [WIDTH-1:0] fb [0:IN-1];
  logic [IDX_W-1:0] idx;
  logic             fb_full;
  logic             rst_q;
  logic             accept;
  logic             at_last;
  logic             xfer;

  // rst_q holds s_ready low for the cycle after reset is first sampled
  assign s_ready = !rst_q && !fb_full;
  assign accept  = s_valid && s_ready;
  assign at_last = (idx == LAST_IDX);
  assign xfer    = fb_full && (!x_valid || x_ack);

  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  // Fill stage: element capture, contents are don't-care after reset
  always_ff @(posedge clk) begin
    if (accept) begin
      fb[idx] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      fb_full <= 1'b0;
      x_valid <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (accept) begin
        if (s_last || at_last) begin
          idx <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
        // short or long frame: drop it, flag, restart at index 0
        if (s_last != at_last) begin
          err <= 1'b1;
        end
      end
      // accept and xfer never coincide: accept needs fb_full=0, xfer needs 1
      if (accept && s_last && at_last) begin
        fb_full <= 1'b1;
      end else if (xfer) begin
        fb_full <= 1'b0;
      end
      if (xfer) begin
        x_valid <= 1'b1;
      end else if (x_ack) begin
        x_valid <= 1'b0;
      end
    end
  end

  // Output stage: whole frame moves in one edge so the layer never sees tearing
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < IN; i++) begin
        x[i] <= '0;
      end
    end else if (xfer) begin
      for (int i = 0; i < IN; i++) begin
        x[i] <= fb[i];
      end
    end
  end

endmodule

// File: tb/tb_fc_in_loader.sv
// Scoreboard bench for fc_in_loader: IN=4 directed cases plus an IN=400 streaming run.
module tb_fc_in_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       v4, l4, ack4, rdy4, xv4, err4;
  logic [7:0] d4;
  logic [7:0] x4 [0:3];
  logic       v400, l400, ack400, rdy400, xv400, err400;
  logic [7:0] d400;
  logic [7:0] x400 [0:399];

  fc_in_loader #(.WIDTH(8), .IN(4)) dut4 (
    .clk(clk), .rst(rst), .s_valid(v4), .s_ready(rdy4), .s_data(d4), .s_last(l4),
    .x(x4), .x_valid(xv4), .x_ack(ack4), .err(err4)
  );

  fc_in_loader #(.WIDTH(8), .IN(400)) dut400 (
    .clk(clk), .rst(rst), .s_valid(v400), .s_ready(rdy400), .s_data(d400), .s_last(l400),
    .x(x400), .x_valid(xv400), .x_ack(ack400), .err(err400)
  );

  int passed = 0;
  int total  = 0;
  logic [31:0]   exp4   [$];
  logic [3199:0] exp400 [$];

  task automatic chk1(input string name, input logic act, input logic req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %b, required %b", name, act, req);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, req);
  endtask

  function automatic logic [31:0] pk4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [31:0] cur4();
    logic [31:0] p;
    for (int i = 0; i < 4; i++) p[i*8 +: 8] = x4[i];
    return p;
  endfunction

  function automatic logic [3199:0] cur400();
    logic [3199:0] p;
    for (int i = 0; i < 400; i++) p[i*8 +: 8] = x400[i];
    return p;
  endfunction

  function automatic int first_diff(input logic [3199:0] a, input logic [3199:0] b);
    for (int i = 0; i < 400; i++) if (a[i*8 +: 8] !== b[i*8 +: 8]) return i;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [7:0] d, input logic l);
    logic r;
    int   n;
    n = 0;
    v4 = 1'b1; d4 = d; l4 = l;
    do begin
      @(negedge clk);
      r = rdy4;
      tick();
      n++;
    end while (!r && n < 200);
    if (!r) begin
      total++;
      $display("FAIL push4_timeout: s_ready stayed %b, required 1", r);
    end
    v4 = 1'b0; l4 = 1'b0;
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic last_on_d);
    push4(a, 1'b0); push4(b, 1'b0); push4(c, 1'b0); push4(d, last_on_d);
  endtask

  task automatic push400(input logic [7:0] d, input logic l);
    logic r;
    int   n;
    n = 0;
    v400 = 1'b1; d400 = d; l400 = l;
    do begin
      @(negedge clk);
      r = rdy400;
      tick();
      n++;
    end while (!r && n < 200);
    if (!r) begin
      total++;
      $display("FAIL push400_timeout: s_ready stayed %b, required 1", r);
    end
    v400 = 1'b0; l400 = 1'b0;
  endtask

  task automatic ack_clear();
    ack4 = 1'b1; tick(); ack4 = 1'b0;
    chk1("ack_clears_x_valid", xv4, 1'b0);
  endtask

  // Monitor for the IN=4 instance: new frame presented, or x must hold still
  logic [31:0] prev_x4;
  logic        prev_xv4 = 1'b0, prev_ack4 = 1'b0, prev_rst4 = 1'b1;
  always @(negedge clk) begin
    logic [31:0] c;
    logic [31:0] e;
    c = cur4();
    if (xv4 && (!prev_xv4 || prev_ack4) && !prev_rst4) begin
      total++;
      if (exp4.size() == 0) begin
        $display("FAIL frame4: got unexpected frame %h, required none", c);
      end else begin
        e = exp4.pop_front();
        if (c === e) passed++;
        else $display("FAIL frame4: got %h, required %h", c, e);
      end
    end else if (!prev_rst4) begin
      total++;
      if (c === prev_x4) passed++;
      else $display("FAIL x4_stable: got %h, required %h", c, prev_x4);
    end
    prev_x4 = c; prev_xv4 = xv4; prev_ack4 = ack4; prev_rst4 = rst;
  end

  logic [3199:0] prev_x400;
  logic          prev_xv400 = 1'b0, prev_ack400 = 1'b0, prev_rst400 = 1'b1;
  always @(negedge clk) begin
    logic [3199:0] c;
    logic [3199:0] e;
    int            k;
    c = cur400();
    if (xv400 && (!prev_xv400 || prev_ack400) && !prev_rst400) begin
      total++;
      if (exp400.size() == 0) begin
        $display("FAIL frame400: got unexpected frame, x[0]=%h, required none", c[7:0]);
      end else begin
        e = exp400.pop_front();
        if (c === e) passed++;
        else begin
          k = first_diff(c, e);
          $display("FAIL frame400: x[%0d] got %h, required %h", k, c[k*8 +: 8], e[k*8 +: 8]);
        end
      end
    end else if (!prev_rst400) begin
      total++;
      if (c === prev_x400) passed++;
      else begin
        k = first_diff(c, prev_x400);
        $display("FAIL x400_stable: x[%0d] got %h, required %h", k, c[k*8 +: 8],
                 prev_x400[k*8 +: 8]);
      end
    end
    prev_x400 = c; prev_xv400 = xv400; prev_ack400 = ack400; prev_rst400 = rst;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    logic [3199:0] f400;
    rst = 1'b1;
    v4 = 1'b0; d4 = '0; l4 = 1'b0; ack4 = 1'b0;
    v400 = 1'b0; d400 = '0; l400 = 1'b0; ack400 = 1'b1;

    tick();
    @(negedge clk);
    chk1("rst_s_ready", rdy4, 1'b0);
    chk1("rst_x_valid", xv4, 1'b0);
    chk1("rst_err", err4, 1'b0);
    chk32("rst_x_zero", cur4(), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk1("ready_after_rst", rdy4, 1'b1);

    // basic frame and latency
    exp4.push_back(pk4(8'd1, 8'd2, 8'd3, 8'd4));
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b1);
    chk1("t1_xv_at_accept", xv4, 1'b0);
    chk1("t1_ready_full", rdy4, 1'b0);
    tick();
    chk1("t1_xv_after_xfer", xv4, 1'b1);
    chk1("t1_ready_after_xfer", rdy4, 1'b1);
    chk1("t1_err", err4, 1'b0);
    ack_clear();

    // back-pressure: B waits in the fill buffer while A is held
    exp4.push_back(pk4(8'd5, 8'd6, 8'd7, 8'd8));
    send4(8'd5, 8'd6, 8'd7, 8'd8, 1'b1);
    tick();
    chk1("t2_xv_a", xv4, 1'b1);
    exp4.push_back(pk4(8'd9, 8'd10, 8'd11, 8'd12));
    send4(8'd9, 8'd10, 8'd11, 8'd12, 1'b1);
    tick(); tick();
    chk1("t2_ready_bp", rdy4, 1'b0);
    chk1("t2_xv_held", xv4, 1'b1);
    chk32("t2_x_held_a", cur4(), pk4(8'd5, 8'd6, 8'd7, 8'd8));
    ack4 = 1'b1; tick(); ack4 = 1'b0;
    chk1("t2_xv_after_ack", xv4, 1'b1);
    chk1("t2_ready_after_ack", rdy4, 1'b1);
    chk32("t2_x_b", cur4(), pk4(8'd9, 8'd10, 8'd11, 8'd12));
    ack_clear();

    // short frame dropped, err sticky
    push4(8'd1, 1'b0); push4(8'd2, 1'b1);
    tick();
    chk1("t3_err_short", err4, 1'b1);
    chk1("t3_no_xv", xv4, 1'b0);
    chk1("t3_ready", rdy4, 1'b1);
    exp4.push_back(pk4(8'd3, 8'd4, 8'd5, 8'd6));
    send4(8'd3, 8'd4, 8'd5, 8'd6, 1'b1);
    tick();
    chk1("t3_err_sticky", err4, 1'b1);
    chk1("t3_xv", xv4, 1'b1);
    ack_clear();

    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk1("t4_err_cleared", err4, 1'b0);

    // long frame dropped, following elements start a new frame
    send4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);
    chk1("t4_err_long", err4, 1'b1);
    chk1("t4_ready", rdy4, 1'b1);
    exp4.push_back(pk4(8'd7, 8'd8, 8'd9, 8'd10));
    send4(8'd7, 8'd8, 8'd9, 8'd10, 1'b1);
    tick();
    chk1("t4_xv", xv4, 1'b1);
    ack_clear();

    // reset with a held frame, then mid-frame
    exp4.push_back(pk4(8'd21, 8'd22, 8'd23, 8'd24));
    send4(8'd21, 8'd22, 8'd23, 8'd24, 1'b1);
    tick();
    chk1("t5_xv_before_rst", xv4, 1'b1);
    rst = 1'b1; tick();
    chk1("t5_rst_xv", xv4, 1'b0);
    chk1("t5_rst_err", err4, 1'b0);
    chk1("t5_rst_ready", rdy4, 1'b0);
    chk32("t5_rst_x_zero", cur4(), 32'h0);
    rst = 1'b0; tick();
    chk1("t5_ready_after_rst", rdy4, 1'b1);
    push4(8'd1, 1'b0); push4(8'd2, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0; tick();
    exp4.push_back(pk4(8'd31, 8'd32, 8'd33, 8'd34));
    send4(8'd31, 8'd32, 8'd33, 8'd34, 1'b1);
    tick();
    chk1("t5_xv_after_partial_rst", xv4, 1'b1);
    chk1("t5_err_after_partial_rst", err4, 1'b0);
    ack_clear();

    // IN=400 streaming with random gaps and x_ack tied high
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 400; i++) f400[i*8 +: 8] = 8'((i * 7 + f) % 256);
      exp400.push_back(f400);
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) tick();
        push400(f400[i*8 +: 8], (i == 399));
      end
    end
    repeat (5) tick();
    chk1("t6_err", err400, 1'b0);
    chk32("queue4_drained", 32'(exp4.size()), 32'h0);
    chk32("queue400_drained", 32'(exp400.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
